// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: widths, FSM encoding and PC helpers.
package fetch_stage_pkg;

    localparam int unsigned PC_WIDTH        = 16;
    localparam int unsigned IR_WIDTH        = 32;
    localparam int unsigned IMEM_ADDR_WIDTH = 10;
    localparam int unsigned INSN_BYTES      = 4;
    localparam logic [IR_WIDTH-1:0] NOP_IR_DEFAULT = 32'h0;

    typedef enum logic {
        StRun    = 1'b0,
        StBrWait = 1'b1
    } fetch_state_e;

    // Branch targets are forced onto an instruction boundary.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-side control/results plus the instruction-memory read port.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                       I_LOCK;
    logic                       I_DepStallSignal;
    logic                       I_BranchStallSignal;
    logic                       I_BranchPCValid;
    logic [PC_WIDTH-1:0]        I_BranchPC;
    logic [IR_WIDTH-1:0]        I_IMemData;
    logic [IMEM_ADDR_WIDTH-1:0] O_IMemAddr;
    logic                       O_LOCK;
    logic [PC_WIDTH-1:0]        O_PC;
    logic [IR_WIDTH-1:0]        O_IR;
    logic                       O_FetchStall;
    logic [31:0]                O_StallCount;

    // Environment side: drives control, branch results and memory data.
    modport master (
        output I_LOCK, I_DepStallSignal, I_BranchStallSignal, I_BranchPCValid, I_BranchPC,
        output I_IMemData,
        input  O_IMemAddr, O_LOCK, O_PC, O_IR, O_FetchStall, O_StallCount
    );

    // Fetch stage side.
    modport slave (
        input  I_LOCK, I_DepStallSignal, I_BranchStallSignal, I_BranchPCValid, I_BranchPC,
        input  I_IMemData,
        output O_IMemAddr, O_LOCK, O_PC, O_IR, O_FetchStall, O_StallCount
    );

endinterface

// File: rtl/fetch_stage.sv
// Front-end fetch stage: owns the PC, reads instruction memory, honours decode stalls and
// branch redirects, and counts bubble cycles.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [IR_WIDTH-1:0] NOP_IR   = NOP_IR_DEFAULT
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET,
    fetch_stage_if.slave      bus
);

    localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(INSN_BYTES);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  lock_q, lock_d;
    logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic                  fetch_stall_q, fetch_stall_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        lock_d        = 1'b0;
        out_pc_d      = out_pc_q;
        ir_d          = ir_q;
        fetch_stall_d = fetch_stall_q;
        stall_cnt_d   = stall_cnt_q;

        if (bus.I_LOCK) begin
            lock_d = 1'b1;
            // Counts the bubble currently being presented, saturating at all-ones.
            if (fetch_stall_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end

            unique case (state_q)
                StRun: begin
                    if (bus.I_DepStallSignal) begin
                        // Decode is busy: re-present the same instruction.
                    end else if (bus.I_BranchStallSignal) begin
                        ir_d          = NOP_IR;
                        fetch_stall_d = 1'b1;
                        state_d       = StBrWait;
                    end else begin
                        ir_d          = bus.I_IMemData;
                        out_pc_d      = pc_q + PcStep;
                        fetch_stall_d = 1'b0;
                        pc_d          = pc_q + PcStep;
                    end
                end
                StBrWait: begin
                    ir_d          = NOP_IR;
                    fetch_stall_d = 1'b1;
                    if (bus.I_BranchPCValid) begin
                        pc_d    = align_pc(bus.I_BranchPC);
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            lock_q        <= 1'b0;
            out_pc_q      <= '0;
            ir_q          <= NOP_IR;
            fetch_stall_q <= 1'b1;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            lock_q        <= lock_d;
            out_pc_q      <= out_pc_d;
            ir_q          <= ir_d;
            fetch_stall_q <= fetch_stall_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.O_IMemAddr   = pc_q[IMEM_ADDR_WIDTH+1:2];
    assign bus.O_LOCK       = lock_q;
    assign bus.O_PC         = out_pc_q;
    assign bus.O_IR         = ir_q;
    assign bus.O_FetchStall = fetch_stall_q;
    assign bus.O_StallCount = stall_cnt_q;

    // PC bits outside the word address do not reach the memory port.
    logic unused_pc;
    assign unused_pc = ^{pc_q[PC_WIDTH-1:IMEM_ADDR_WIDTH+2], pc_q[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random traffic, all
// compared against a behavioural model of the fetch stage.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_IR   (32'h0)
    ) dut (
        .I_CLOCK (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    logic [31:0] imem [1024];
    assign bus.I_IMemData = imem[bus.O_IMemAddr];

    int checks = 0;
    int errors = 0;

    // Behavioural model: the address fetched next, whether a redirect is awaited, and what
    // the decode stage currently sees.
    logic [15:0] m_next_pc;
    bit          m_waiting;
    logic        m_lock;
    logic [15:0] m_out_pc;
    logic [31:0] m_ir;
    logic        m_bubble;
    logic [31:0] m_bubbles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("O_LOCK",       32'(bus.O_LOCK),       32'(m_lock));
        chk("O_PC",         32'(bus.O_PC),         32'(m_out_pc));
        chk("O_IR",         bus.O_IR,              m_ir);
        chk("O_FetchStall", 32'(bus.O_FetchStall), 32'(m_bubble));
        chk("O_StallCount", bus.O_StallCount,      m_bubbles);
        chk("O_IMemAddr",   32'(bus.O_IMemAddr),   32'(m_next_pc[11:2]));
    endtask

    task automatic model_reset();
        m_next_pc = 16'h0000;
        m_waiting = 1'b0;
        m_lock    = 1'b0;
        m_out_pc  = 16'h0000;
        m_ir      = 32'h0;
        m_bubble  = 1'b1;
        m_bubbles = 0;
    endtask

    // One enabled or disabled cycle of the model, computed from the inputs seen before the edge.
    task automatic model_step(input bit lock, input bit dep, input bit br, input bit valid,
                              input logic [15:0] bpc);
        if (!lock) begin
            m_lock = 1'b0;
            return;
        end
        m_lock = 1'b1;
        if (m_bubble && m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
        if (m_waiting) begin
            m_ir     = 32'h0;
            m_bubble = 1'b1;
            if (valid) begin
                m_next_pc = bpc & 16'hFFFC;
                m_waiting = 1'b0;
            end
        end else if (dep) begin
            // same instruction stays visible
        end else if (br) begin
            m_ir      = 32'h0;
            m_bubble  = 1'b1;
            m_waiting = 1'b1;
        end else begin
            m_ir      = imem[m_next_pc[11:2]];
            m_next_pc = m_next_pc + 16'd4;
            m_out_pc  = m_next_pc;
            m_bubble  = 1'b0;
        end
    endtask

    task automatic cyc(input bit lock, input bit dep, input bit br, input bit valid,
                       input logic [15:0] bpc);
        bus.I_LOCK              = lock;
        bus.I_DepStallSignal    = dep;
        bus.I_BranchStallSignal = br;
        bus.I_BranchPCValid     = valid;
        bus.I_BranchPC          = bpc;
        model_step(lock, dep, br, valid, bpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    logic [31:0] cnt_before;

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        imem[0] = 32'hA000_000A;
        imem[1] = 32'hB000_000B;
        imem[2] = 32'hC000_000C;
        imem[3] = 32'hD000_000D;
        bus.I_LOCK = 1'b0; bus.I_DepStallSignal = 1'b0; bus.I_BranchStallSignal = 1'b0;
        bus.I_BranchPCValid = 1'b0; bus.I_BranchPC = '0;
        #2;

        // Reset values
        do_reset();
        chk("rst_fetchstall", 32'(bus.O_FetchStall), 32'd1);
        chk("rst_count", bus.O_StallCount, 32'd0);

        // Straight-line fetch A..D
        cyc(1, 0, 0, 0, 0); chk("ir_A", bus.O_IR, 32'hA000_000A);
        cyc(1, 0, 0, 0, 0); chk("ir_B", bus.O_IR, 32'hB000_000B);
        cyc(1, 0, 0, 0, 0); chk("ir_C", bus.O_IR, 32'hC000_000C);
        cyc(1, 0, 0, 0, 0); chk("ir_D", bus.O_IR, 32'hD000_000D);
        chk("pc_16", 32'(bus.O_PC), 32'd16);
        chk("count_1", bus.O_StallCount, 32'd1);

        // Dependency stall holding B
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cnt_before = bus.O_StallCount;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0);
            chk("dep_ir_B", bus.O_IR, 32'hB000_000B);
            chk("dep_addr", 32'(bus.O_IMemAddr), 32'd2);
        end
        cyc(1, 0, 0, 0, 0); chk("after_dep_C", bus.O_IR, 32'hC000_000C);
        chk("dep_count", bus.O_StallCount, cnt_before);

        // Branch stall, redirect to 0x40 three cycles later
        cnt_before = bus.O_StallCount;
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 16'h0040);
        chk("br_bubble", 32'(bus.O_FetchStall), 32'd1);
        cyc(1, 0, 0, 0, 0);
        chk("br_target_ir", bus.O_IR, imem[16]);
        chk("br_target_pc", 32'(bus.O_PC), 32'h44);
        chk("br_count_4", bus.O_StallCount, cnt_before + 32'd4);

        // Dep and branch together, then misaligned target
        cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
        chk("both_hold", bus.O_IR, imem[16]);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 16'h0043);
        cyc(1, 0, 0, 0, 0);
        chk("align_pc", 32'(bus.O_PC), 32'h44);

        // PC wrap
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 16'hFFFC);
        chk("wrap_addr", 32'(bus.O_IMemAddr), 32'h3FF);
        cyc(1, 0, 0, 0, 0);
        chk("wrap_pc", 32'(bus.O_PC), 32'h0);

        // Reset while waiting for a redirect; late pulse ignored
        cyc(1, 0, 1, 0, 0);
        do_reset();
        cyc(1, 0, 0, 1, 16'h0100);
        chk("rst_wait_ir", bus.O_IR, 32'hA000_000A);
        chk("rst_wait_pc", 32'(bus.O_PC), 32'd4);

        // Lock low freezes everything but O_LOCK
        for (int i = 0; i < 5; i++) begin
            cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 16'(
                $urandom));
            chk("unlocked", 32'(bus.O_LOCK), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0, 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end pipeline stage. Holds the program counter and reads the instruction memory.
- Drives the PC/IR/fetch-stall interface that the decode stage consumes.
- Obeys the decode stage's dependency-stall and branch-stall signals. Redirects the PC when the resolved branch target returns.
- Counts bubble cycles for performance reporting.

Parameters:
- PC_WIDTH, 16, PC width in bits (matches global_def.h `PC_WIDTH).
- IR_WIDTH, 32, instruction width in bits.
- IMEM_ADDR_WIDTH, 10, instruction-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_IR, 32'h0, bubble instruction word. Its opcode must not be a branch or jump.

Ports:
- I_CLOCK  in  1  clock; all state updates on posedge.
- I_RESET  in  1  synchronous reset, active-high.
- I_LOCK  in  1  pipeline enable; when 0 all state is frozen.
- I_DepStallSignal  in  1  decode cannot accept a new instruction; hold the current one.
- I_BranchStallSignal  in  1  decode holds a branch/jump; stop fetching.
- I_BranchPCValid  in  1  one-cycle pulse: resolved next PC is available.
- I_BranchPC  in  PC_WIDTH  resolved next PC (taken target or fall-through).
- I_IMemData  in  IR_WIDTH  combinational read data for O_IMemAddr.
- O_IMemAddr  out  IMEM_ADDR_WIDTH  word address = PC[IMEM_ADDR_WIDTH+1:2].
- O_LOCK  out  1  registered copy of I_LOCK.
- O_PC  out  PC_WIDTH  address of the presented instruction + 4.
- O_IR  out  IR_WIDTH  presented instruction.
- O_FetchStall  out  1  1 = O_IR is a bubble and decode treats it as NOP.
- O_StallCount  out  32  number of cycles with O_FetchStall=1 and I_LOCK=1; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (posedge, I_RESET=1; wins over every other input):
  - PC<=RESET_PC, state<=RUN, O_LOCK<=0, O_PC<=0, O_IR<=NOP_IR, O_FetchStall<=1, O_StallCount<=0.
- When I_LOCK=0: O_LOCK<=0 and nothing else changes.
- Otherwise O_LOCK<=1, and the two-state FSM applies.
- State RUN, checked in priority order:
  1. I_DepStallSignal=1: hold PC, O_PC, O_IR and O_FetchStall unchanged (re-present the same instruction). This takes priority over I_BranchStallSignal.
  2. I_BranchStallSignal=1: O_IR<=NOP_IR, O_FetchStall<=1, PC frozen, state<=BR_WAIT.
  3. Else: O_IR<=I_IMemData, O_PC<=PC+4, O_FetchStall<=0, PC<=PC+4.
- State BR_WAIT:
  - Keep presenting the bubble (O_IR=NOP_IR, O_FetchStall=1).
  - Ignore I_DepStallSignal and I_BranchStallSignal.
  - On I_BranchPCValid=1: PC<={I_BranchPC[PC_WIDTH-1:2],2'b00}, state<=RUN. The first fetch from the new PC appears on the following posedge.
- I_BranchPCValid while in RUN is ignored.
- Latency:
  - Fetch to O_IR: 1 cycle.
  - Redirect: the branch pulse at edge N produces the target instruction on O_IR at edge N+1.
- PC arithmetic is modulo 2^PC_WIDTH; 16'hFFFC+4 wraps to 16'h0000.
- O_IMemAddr is combinational from the PC register and stays stable in the hold and wait states.
- O_StallCount increments on every enabled posedge whose registered O_FetchStall (pre-update) is 1. This includes the bubble immediately after reset.
- Reset mid-BR_WAIT discards the pending redirect. A late I_BranchPCValid after reset is ignored (state=RUN).

Decomposition:
- global_def.h gains:
  - `FETCH_ST_RUN / `FETCH_ST_BRWAIT (1-bit encoding).
  - `NOP_IR default.
  - `INSN_BYTES (4).
- PC_WIDTH/IR_WIDTH/opcode defines are reused from global_def.h.
- No sub-module needed. The saturating counter is inline (about 10 lines).

Test Plan:
- Reset, then I_LOCK=1 with IMEM[0..3]=A,B,C,D and no stalls -> O_IR=A,B,C,D with O_PC=4,8,12,16 on successive edges; O_FetchStall=0 after the first edge; O_StallCount=1.
- I_DepStallSignal=1 for 3 cycles while O_IR=B (O_PC=8) -> O_IR=B, O_PC=8, O_IMemAddr=2 for all 3 cycles; then C at O_PC=12; O_StallCount unchanged.
- Branch at O_PC=12 asserts I_BranchStallSignal; I_BranchPCValid pulses 3 cycles later with I_BranchPC=16'h0040 -> 4 bubble cycles (O_FetchStall=1, O_IR=NOP_IR); then O_IR=IMEM[16], O_PC=16'h0044; O_StallCount rises by 4.
- I_DepStallSignal and I_BranchStallSignal both 1 for 2 cycles, then dep drops -> branch held 2 cycles, then BR_WAIT entered; no instruction lost.
- I_BranchPC=16'h0043 -> fetch from 16'h0040. PC=16'hFFFC, no stall -> next O_PC=16'h0000.
- I_RESET during BR_WAIT, then I_BranchPCValid=1 with 16'h0100 -> fetch restarts at RESET_PC and the pulse is ignored. I_LOCK=0 for 5 cycles -> all outputs frozen except O_LOCK=0.
